score_arbiter: RTL

Arbitrates score-award events from several gameplay sources into the single score register and the shared binary-to-BCD converter that feeds the on-screen score digits. Each source raises a level request; the block edge-detects it, queues a small per-source backlog, grants sources round-robin, adds the source's point value with saturation at 9999, and sequences one conversion per score change through a start/done handshake. It sits between the gameplay modules (enemy, pickup, level logic) and the score display path, and replaces ad-hoc per-source score registers.

---
 rtl/score_pkg.sv | 28 ++
 rtl/score_arbiter_rr_picker.sv | 28 ++
 rtl/score_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared constants, state encoding and saturating add for score_arbiter
package score_pkg;
   localparam int NUM_SRC   = 4;
   localparam int PEND_W    = 2;
   localparam int SCORE_W   = 14;
   localparam int MAX_SCORE = 9999;

   localparam logic [14:0] MAX_SCORE_W = 15'(MAX_SCORE);
   localparam logic [13:0] MAX_SCORE_V = 14'(MAX_SCORE);

   // enemy, block, item, level clear
   localparam logic [SCORE_W-1:0] POINTS [NUM_SRC] = '{14'd10, 14'd50, 14'd100, 14'd500};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] w_sum;
      w_sum = {1'b0, a} + {1'b0, b};
      if (w_sum > MAX_SCORE_W)
         return MAX_SCORE_V;
      return w_sum[SCORE_W-1:0];
   endfunction
endpackage

// File: rtl/score_arbiter_rr_picker.sv
// rtl/score_arbiter_rr_picker.sv - combinational round-robin winner search starting at i_ptr
module rr_picker
   import score_pkg::*;
#(
   parameter int N     = NUM_SRC,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [IDX_W-1:0] o_winner,
   output logic             o_valid
);
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      o_winner = '0;
      o_valid  = 1'b0;
      w_idx    = '0;
      // scan from the far end so the source nearest i_ptr is assigned last and wins
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = IDX_W'((int'(i_ptr) + k) % N);
         if (i_req[w_idx]) begin
            o_winner = w_idx;
            o_valid  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/score_arbiter.sv
// rtl/score_arbiter.sv - round-robin score award arbiter with saturating score and BCD start/done sequencing
module score_arbiter
   import score_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] award_req,
   input  logic               clear,
   input  logic               game_over,
   input  logic               bcd_done,
   output logic               bcd_start,
   output logic [SCORE_W-1:0] bcd_in,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               busy,
   output logic [NUM_SRC-1:0] award_drop
);
   localparam int IDX_W = $clog2(NUM_SRC);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_t             r_state, w_next;
   logic [NUM_SRC-1:0] r_req, r_drop;
   logic [NUM_SRC-1:0] w_event, w_dec, w_drop, w_pend_nz;
   logic [PEND_W-1:0]  r_pend [NUM_SRC];
   logic [IDX_W-1:0]   r_rr_ptr, w_winner;
   logic               w_valid, w_grant;
   logic [SCORE_W-1:0] r_score, r_high, r_bcd_in, w_score_nxt;
   logic               r_redo;

   assign w_event = award_req & ~r_req;

   always_comb begin
      w_pend_nz = '0;
      for (int i = 0; i < NUM_SRC; i++)
         w_pend_nz[i] = |r_pend[i];
   end

   rr_picker #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr_picker (
      .i_req    (w_pend_nz),
      .i_ptr    (r_rr_ptr),
      .o_winner (w_winner),
      .o_valid  (w_valid)
   );

   // clear outranks a grant; the pending backlog is wiped in the same cycle
   assign w_grant     = (r_state == ST_IDLE) && w_valid && !clear;
   assign w_score_nxt = clear   ? '0 :
                        w_grant ? sat_add(r_score, POINTS[w_winner]) : r_score;

   always_comb begin
      w_dec  = '0;
      w_drop = '0;
      if (w_grant)
         w_dec[w_winner] = 1'b1;
      for (int i = 0; i < NUM_SRC; i++)
         w_drop[i] = w_event[i] && (r_pend[i] == PEND_MAX) && !w_dec[i] && !clear;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   // a done that coincides with clear still needs a fresh conversion of the cleared score
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (clear || w_grant) w_next = ST_START;
         ST_START: if (!clear) w_next = ST_WAIT;
         ST_WAIT:  if (bcd_done) w_next = (r_redo || clear) ? ST_START : ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      bcd_start = (r_state == ST_START);
      busy      = (r_state != ST_IDLE) || (|w_pend_nz);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SRC; i++)
            r_pend[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (clear)
               r_pend[i] <= '0;
            else if (w_event[i] && !w_dec[i] && (r_pend[i] != PEND_MAX))
               r_pend[i] <= r_pend[i] + PEND_W'(1);
            else if (w_dec[i] && !w_event[i])
               r_pend[i] <= r_pend[i] - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_req    <= '0;
         r_drop   <= '0;
         r_score  <= '0;
         r_high   <= '0;
         r_bcd_in <= '0;
         r_rr_ptr <= '0;
         r_redo   <= 1'b0;
      end else begin
         r_req   <= award_req;
         r_drop  <= w_drop;
         r_score <= w_score_nxt;
         if (game_over && (r_score > r_high))
            r_high <= r_score;
         // loaded on entry so the value is already valid while bcd_start is high
         if (w_next == ST_START)
            r_bcd_in <= w_score_nxt;
         if (w_grant)
            r_rr_ptr <= (w_winner == IDX_W'(NUM_SRC - 1)) ? '0 : w_winner + IDX_W'(1);
         if (r_state == ST_WAIT) begin
            if (bcd_done)
               r_redo <= 1'b0;
            else if (clear)
               r_redo <= 1'b1;
         end
      end
   end

   assign score      = r_score;
   assign high_score = r_high;
   assign bcd_in     = r_bcd_in;
   assign award_drop = r_drop;
endmodule
